// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline.
//   MEMOP_*          : access size/sign codes carried with memory instructions
//   JAL_LINK_OFFSET  : jal writes pc+8 (skips the delay slot) into $ra
//   store_byte_en()  : byte-lane enables for a store of a given size/offset
package mips_pkg;

  localparam int MEMOP_W = 3;
  typedef logic [MEMOP_W-1:0] memop_t;

  localparam memop_t MEMOP_WORD  = 3'd0;
  localparam memop_t MEMOP_HALF  = 3'd1;
  localparam memop_t MEMOP_HALFU = 3'd2;
  localparam memop_t MEMOP_BYTE  = 3'd3;
  localparam memop_t MEMOP_BYTEU = 3'd4;

  localparam logic [31:0] JAL_LINK_OFFSET = 32'd8;

  // Reserved codes (5-7) fall into the default and behave as a full word.
  function automatic logic [3:0] store_byte_en(input memop_t op, input logic [1:0] lo);
    case (op)
      MEMOP_HALF, MEMOP_HALFU: return lo[1] ? 4'b1100 : 4'b0011;
      MEMOP_BYTE, MEMOP_BYTEU: return 4'b0001 << lo;
      default:                 return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mw_stage_if.sv
// M-stage inputs and W-stage outputs of the memory stage.
//   slave  : the mw_stage side (consumes M signals, drives Fwd_M and W signals)
//   master : the pipeline side (drives M signals, observes Fwd_M and W signals)
interface mw_stage_if;
  import mips_pkg::*;

  logic        RegWrite_M;
  logic        MemtoReg_M;
  logic        MemWrite_M;
  memop_t      MemOp_M;
  logic [31:0] ALUOut_M;
  logic [31:0] WriteData_M;
  logic [4:0]  WriteReg_M;
  logic [31:0] pc_M;
  logic        jal_M;

  logic [31:0] Fwd_M;
  logic        RegWrite_W;
  logic [4:0]  WriteReg_W;
  logic [31:0] Result_W;
  logic [31:0] pc_W;

  modport slave (
    input  RegWrite_M, MemtoReg_M, MemWrite_M, MemOp_M, ALUOut_M,
           WriteData_M, WriteReg_M, pc_M, jal_M,
    output Fwd_M, RegWrite_W, WriteReg_W, Result_W, pc_W
  );

  modport master (
    output RegWrite_M, MemtoReg_M, MemWrite_M, MemOp_M, ALUOut_M,
           WriteData_M, WriteReg_M, pc_M, jal_M,
    input  Fwd_M, RegWrite_W, WriteReg_W, Result_W, pc_W
  );
endinterface

// File: rtl/data_mem.sv
// Word-organised data memory with byte-lane stores and combinational read.
//   clk, reset : clock and synchronous active-high clear of every word
//   we         : store enable (ignored while reset is high)
//   addr       : byte address; addresses >= 4*2**DM_ADDR_W are out of range
//   wdata      : store data (low half/byte used for narrow stores)
//   size       : memop code selecting word/half/byte store
//   rdata      : whole word at addr, 0 when out of range
module data_mem
  import mips_pkg::*;
#(
  parameter int DM_ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  memop_t      size,
  output logic [31:0] rdata
);

  localparam int          DEPTH      = 2**DM_ADDR_W;
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH);

  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic                 in_range;
  logic [DM_ADDR_W-1:0] idx;
  logic [31:0]          word_rd;
  logic [31:0]          wdata_rep;
  logic [31:0]          word_d;
  logic [3:0]           be;

  // Compare in 33 bits so the limit itself is representable for any depth.
  assign in_range = {1'b0, addr} < BYTE_LIMIT;
  assign idx      = addr[DM_ADDR_W+1:2];
  assign word_rd  = mem_q[idx];
  assign rdata    = in_range ? word_rd : '0;
  assign be       = store_byte_en(size, addr[1:0]);

  // Replicate narrow data across all lanes; the byte enables pick the lane.
  always_comb begin
    wdata_rep = wdata;
    case (size)
      MEMOP_HALF, MEMOP_HALFU: wdata_rep = {2{wdata[15:0]}};
      MEMOP_BYTE, MEMOP_BYTEU: wdata_rep = {4{wdata[7:0]}};
      default:                 wdata_rep = wdata;
    endcase
  end

  // Read-modify-write merge: unselected lanes keep the current word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_d[gi*8 +: 8] = be[gi] ? wdata_rep[gi*8 +: 8] : word_rd[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && in_range) begin
      mem_q[idx] <= word_d;
    end
  end

endmodule

// File: rtl/mw_stage.sv
// Memory stage plus M/W pipeline register of the 5-stage MIPS core.
//   clk, reset : clock and synchronous active-high reset
//   bus        : M-stage control/data in, Fwd_M (combinational forward to the
//                hazard unit) and registered W-stage outputs
// Result priority: jal link address, then extended load data, then ALU result.
module mw_stage
  import mips_pkg::*;
#(
  parameter int DM_ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  mw_stage_if.slave   bus
);

  logic [31:0] load_word;
  logic [31:0] load_ext;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] link_addr;

  logic        regwrite_d;
  logic [31:0] result_d;

  logic        regwrite_q = 1'b0;
  logic [4:0]  writereg_q = '0;
  logic [31:0] result_q   = '0;
  logic [31:0] pc_q       = '0;

  data_mem #(.DM_ADDR_W(DM_ADDR_W)) u_dmem (
    .clk   (clk),
    .reset (reset),
    .we    (bus.MemWrite_M),
    .addr  (bus.ALUOut_M),
    .wdata (bus.WriteData_M),
    .size  (bus.MemOp_M),
    .rdata (load_word)
  );

  // The read is from the array before this edge's store lands, so a
  // simultaneous store+load returns the pre-store word.
  always_comb begin
    half_sel = bus.ALUOut_M[1] ? load_word[31:16] : load_word[15:0];
    case (bus.ALUOut_M[1:0])
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase
    case (bus.MemOp_M)
      MEMOP_HALF:  load_ext = {{16{half_sel[15]}}, half_sel};
      MEMOP_HALFU: load_ext = {16'h0000, half_sel};
      MEMOP_BYTE:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_BYTEU: load_ext = {24'h000000, byte_sel};
      default:     load_ext = load_word;
    endcase
  end

  assign link_addr = bus.pc_M + JAL_LINK_OFFSET;
  assign bus.Fwd_M = bus.jal_M ? link_addr : bus.ALUOut_M;

  always_comb begin
    regwrite_d = bus.RegWrite_M && (bus.WriteReg_M != 5'd0);
    if (bus.jal_M) begin
      result_d = link_addr;
    end else if (bus.MemtoReg_M) begin
      result_d = load_ext;
    end else begin
      result_d = bus.ALUOut_M;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      writereg_q <= '0;
      result_q   <= '0;
      pc_q       <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      writereg_q <= bus.WriteReg_M;
      result_q   <= result_d;
      pc_q       <= bus.pc_M;
    end
  end

  assign bus.RegWrite_W = regwrite_q;
  assign bus.WriteReg_W = writereg_q;
  assign bus.Result_W   = result_q;
  assign bus.pc_W       = pc_q;

endmodule

// File: tb/tb_mw_stage.sv
module tb_mw_stage;
  import mips_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mw_stage_if bus();

  mw_stage #(.DM_ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] res;
    logic [31:0] pc;
  } wexp_t;

  typedef struct {
    string       name;
    logic [31:0] fwd;
  } fexp_t;

  wexp_t w_q[$];
  fexp_t f_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    m_valid   = 1'b0;
  bit    w_pending = 1'b0;

  // Monitor: on each falling edge, check the W outputs of the instruction
  // captured at the previous rising edge, then Fwd_M of the one now in M.
  always @(negedge clk) begin
    wexp_t we;
    fexp_t fe;
    if (w_pending) begin
      n_vec++;
      if (w_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: W output with no expected entry");
      end else begin
        we = w_q.pop_front();
        if (bus.RegWrite_W !== we.rw || bus.WriteReg_W !== we.wr ||
            bus.Result_W !== we.res || bus.pc_W !== we.pc) begin
          n_err++;
          $display("FAIL %s W: got rw=%0d wr=%0d res=%h pc=%h, want rw=%0d wr=%0d res=%h pc=%h",
                   we.name, bus.RegWrite_W, bus.WriteReg_W, bus.Result_W, bus.pc_W,
                   we.rw, we.wr, we.res, we.pc);
        end else begin
          $display("ok   %s W: rw=%0d wr=%0d res=%h pc=%h",
                   we.name, bus.RegWrite_W, bus.WriteReg_W, bus.Result_W, bus.pc_W);
        end
      end
    end
    if (m_valid) begin
      n_vec++;
      if (f_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: Fwd_M with no expected entry");
      end else begin
        fe = f_q.pop_front();
        if (bus.Fwd_M !== fe.fwd) begin
          n_err++;
          $display("FAIL %s Fwd_M: got %h, want %h", fe.name, bus.Fwd_M, fe.fwd);
        end
      end
    end
    w_pending = m_valid;
  end

  task automatic clear_inputs();
    bus.RegWrite_M  = 1'b0;
    bus.MemtoReg_M  = 1'b0;
    bus.MemWrite_M  = 1'b0;
    bus.MemOp_M     = MEMOP_WORD;
    bus.ALUOut_M    = '0;
    bus.WriteData_M = '0;
    bus.WriteReg_M  = '0;
    bus.pc_M        = '0;
    bus.jal_M       = 1'b0;
  endtask

  // Drive one instruction into M for one cycle and queue its expectations.
  task automatic issue(input string name, input logic rst,
                       input logic rw, input logic mtr, input logic mw, input memop_t op,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                       input logic [31:0] pc, input logic jal,
                       input logic [31:0] exp_fwd, input logic exp_rw, input logic [31:0] exp_res);
    wexp_t we;
    fexp_t fe;
    reset           = rst;
    bus.RegWrite_M  = rw;
    bus.MemtoReg_M  = mtr;
    bus.MemWrite_M  = mw;
    bus.MemOp_M     = op;
    bus.ALUOut_M    = alu;
    bus.WriteData_M = wd;
    bus.WriteReg_M  = wr;
    bus.pc_M        = pc;
    bus.jal_M       = jal;
    fe.name = name;
    fe.fwd  = exp_fwd;
    f_q.push_back(fe);
    we.name = name;
    we.rw   = rst ? 1'b0 : exp_rw;
    we.wr   = rst ? 5'd0 : wr;
    we.res  = rst ? 32'd0 : exp_res;
    we.pc   = rst ? 32'd0 : pc;
    w_q.push_back(we);
    m_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    #2;
    n_vec++;
    if (bus.RegWrite_W !== 1'b0 || bus.WriteReg_W !== 5'd0 ||
        bus.Result_W !== 32'd0 || bus.pc_W !== 32'd0) begin
      n_err++;
      $display("FAIL power_up: got rw=%0d wr=%0d res=%h pc=%h, want all zero",
               bus.RegWrite_W, bus.WriteReg_W, bus.Result_W, bus.pc_W);
    end
    @(posedge clk);
    #1;
    //     name        rst rw mtr mw op           alu            wdata          wr     pc             jal  fwd            rw  result
    issue("reset",     1, 0, 0, 0, MEMOP_WORD,  32'h0,         32'h0,         5'd0,  32'h0,         0, 32'h0,         0, 32'h0);
    issue("sw_10",     0, 0, 0, 1, MEMOP_WORD,  32'h10,        32'h12345678,  5'd0,  32'h100,       0, 32'h10,        0, 32'h10);
    issue("lw_10",     0, 1, 1, 0, MEMOP_WORD,  32'h10,        32'h0,         5'd8,  32'h104,       0, 32'h10,        1, 32'h12345678);
    issue("sw_20",     0, 0, 0, 1, MEMOP_WORD,  32'h20,        32'h0,         5'd0,  32'h108,       0, 32'h20,        0, 32'h20);
    issue("sb_23",     0, 0, 0, 1, MEMOP_BYTE,  32'h23,        32'h0000009A,  5'd0,  32'h10C,       0, 32'h23,        0, 32'h23);
    issue("sh_20",     0, 0, 0, 1, MEMOP_HALF,  32'h20,        32'h0000BEEF,  5'd0,  32'h110,       0, 32'h20,        0, 32'h20);
    issue("lw_20",     0, 1, 1, 0, MEMOP_WORD,  32'h20,        32'h0,         5'd9,  32'h114,       0, 32'h20,        1, 32'h9A00BEEF);
    issue("lb_23",     0, 1, 1, 0, MEMOP_BYTE,  32'h23,        32'h0,         5'd10, 32'h118,       0, 32'h23,        1, 32'hFFFFFF9A);
    issue("lbu_23",    0, 1, 1, 0, MEMOP_BYTEU, 32'h23,        32'h0,         5'd11, 32'h11C,       0, 32'h23,        1, 32'h0000009A);
    issue("lh_20",     0, 1, 1, 0, MEMOP_HALF,  32'h20,        32'h0,         5'd12, 32'h120,       0, 32'h20,        1, 32'hFFFFBEEF);
    issue("lhu_20",    0, 1, 1, 0, MEMOP_HALFU, 32'h20,        32'h0,         5'd13, 32'h124,       0, 32'h20,        1, 32'h0000BEEF);
    issue("lh_22",     0, 1, 1, 0, MEMOP_HALF,  32'h22,        32'h0,         5'd14, 32'h128,       0, 32'h22,        1, 32'hFFFF9A00);
    issue("lb_21",     0, 1, 1, 0, MEMOP_BYTE,  32'h21,        32'h0,         5'd15, 32'h12C,       0, 32'h21,        1, 32'hFFFFFFBE);
    issue("lbu_20",    0, 1, 1, 0, MEMOP_BYTEU, 32'h20,        32'h0,         5'd16, 32'h130,       0, 32'h20,        1, 32'h000000EF);
    issue("jal",       0, 1, 0, 0, MEMOP_WORD,  32'h1234,      32'h0,         5'd31, 32'h00003000,  1, 32'h00003008,  1, 32'h00003008);
    issue("jal_wrap",  0, 1, 0, 0, MEMOP_WORD,  32'h0,         32'h0,         5'd31, 32'hFFFFFFFC,  1, 32'h00000004,  1, 32'h00000004);
    issue("wr_zero",   0, 1, 0, 0, MEMOP_WORD,  32'h55,        32'h0,         5'd0,  32'h134,       0, 32'h55,        0, 32'h55);
    issue("alu_pass",  0, 1, 0, 0, MEMOP_WORD,  32'hDEADBEEF,  32'h0,         5'd5,  32'h138,       0, 32'hDEADBEEF,  1, 32'hDEADBEEF);
    issue("sw_oor",    0, 0, 0, 1, MEMOP_WORD,  32'h4000,      32'hCAFEBABE,  5'd0,  32'h13C,       0, 32'h4000,      0, 32'h4000);
    issue("lw_oor",    0, 1, 1, 0, MEMOP_WORD,  32'h4000,      32'h0,         5'd6,  32'h140,       0, 32'h4000,      1, 32'h0);
    issue("lw_0_alias",0, 1, 1, 0, MEMOP_WORD,  32'h0,         32'h0,         5'd7,  32'h144,       0, 32'h0,         1, 32'h0);
    issue("st_ld_both",0, 1, 1, 1, MEMOP_WORD,  32'h10,        32'h11111111,  5'd3,  32'h148,       0, 32'h10,        1, 32'h12345678);
    issue("lw_10_new", 0, 1, 1, 0, MEMOP_WORD,  32'h10,        32'h0,         5'd4,  32'h14C,       0, 32'h10,        1, 32'h11111111);
    issue("lw_rsvd6",  0, 1, 1, 0, 3'd6,        32'h12,        32'h0,         5'd17, 32'h150,       0, 32'h12,        1, 32'h11111111);
    issue("sw_0",      0, 0, 0, 1, MEMOP_WORD,  32'h0,         32'hAAAAAAAA,  5'd0,  32'h154,       0, 32'h0,         0, 32'h0);
    issue("lw_0_pre",  0, 1, 1, 0, MEMOP_WORD,  32'h0,         32'h0,         5'd18, 32'h158,       0, 32'h0,         1, 32'hAAAAAAAA);
    issue("rst_sw_4",  1, 1, 0, 1, MEMOP_WORD,  32'h4,         32'h55555555,  5'd19, 32'h15C,       0, 32'h4,         0, 32'h0);
    issue("lw_0_post", 0, 1, 1, 0, MEMOP_WORD,  32'h0,         32'h0,         5'd20, 32'h160,       0, 32'h0,         1, 32'h0);
    issue("lw_4_post", 0, 1, 1, 0, MEMOP_WORD,  32'h4,         32'h0,         5'd21, 32'h164,       0, 32'h4,         1, 32'h0);
    issue("lw_10_post",0, 1, 1, 0, MEMOP_WORD,  32'h10,        32'h0,         5'd22, 32'h168,       0, 32'h10,        1, 32'h0);
    m_valid = 1'b0;
    clear_inputs();
    for (int i = 0; i < 10 && (w_q.size() != 0 || w_pending); i++) begin
      @(posedge clk);
      #1;
    end
    if (w_q.size() != 0 || f_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d W and %0d Fwd entries pending, want 0", w_q.size(), f_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mw_stage.md
Name: mw_stage

Overview:
- Memory stage plus M/W pipeline register of the 5-stage MIPS core.
- Consumes the outputs of the E/M register: control, ALU result, store data, destination register, PC and jal flag.
- Holds the data memory, performs word/half/byte stores and loads, and registers the final write-back value into the W stage.
- Also drives a combinational M-stage forwarding value to the hazard unit.

Parameters:
DM_ADDR_W, 12, word-address width of data memory (2**DM_ADDR_W words, byte range 0 .. 4*2**DM_ADDR_W-1)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
RegWrite_M  input  1  instruction in M writes the register file
MemtoReg_M  input  1  write-back value comes from memory
MemWrite_M  input  1  store enable
MemOp_M  input  3  access size/sign code (package constants)
ALUOut_M  input  32  byte address for memory ops, else ALU result
WriteData_M  input  32  store data, already forwarded upstream
WriteReg_M  input  5  destination register
pc_M  input  32  PC of instruction in M
jal_M  input  1  instruction is jal; result is pc+8
Fwd_M  output  32  combinational forward value: pc_M+8 if jal_M, else ALUOut_M
RegWrite_W  output  1  registered write enable
WriteReg_W  output  5  registered destination
Result_W  output  32  registered write-back value
pc_W  output  32  registered PC

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset (posedge clk with reset=1):
  - Every data-memory word becomes 0.
  - RegWrite_W=0, WriteReg_W=0, Result_W=0, pc_W=0.
  - Any store presented in the same cycle is dropped.
  - Reset mid-stream discards the instruction in M entirely.
- Initial values: all registered outputs and memory start at 0 from time zero, before the first reset.
- Address decode:
  - word index = ALUOut_M[DM_ADDR_W+1:2].
  - Out of range means ALUOut_M >= 4*2**DM_ADDR_W: stores are ignored and loads return 0.
- Store (MemWrite_M=1, reset=0): memory updates at the posedge.
  - Word: addr[1:0] ignored; the full word is written.
  - Half: addr[0] ignored; addr[1] selects the lane; WriteData_M[15:0] is written; the other half is untouched.
  - Byte: addr[1:0] selects the lane; WriteData_M[7:0] is written; other bytes are untouched.
- Load read path: combinational from the array. A load in M in the cycle after a store to the same word sees the stored data.
- Load data selection:
  - Word: the full word.
  - Half signed/unsigned: lane selected by addr[1], then sign- or zero-extended to 32.
  - Byte signed/unsigned: lane selected by addr[1:0], then extended.
- MemOp codes 5-7 are reserved and behave as word.
- Result select, registered at the posedge into Result_W:
  - jal_M has priority: pc_M+8, modulo 2**32.
  - Otherwise MemtoReg_M selects the extended load data.
  - Otherwise ALUOut_M.
- RegWrite_W <= RegWrite_M && (WriteReg_M != 0). A write to $0 is never signalled.
- WriteReg_W and pc_W are passed through unchanged.
- Latency: one cycle from M-stage inputs to W outputs. No stall and no flush inputs; every cycle advances.
- MemWrite_M and MemtoReg_M both 1 is an illegal decode. Required response: the store happens, and Result_W takes the pre-store word.

Decomposition:
- Shared package mips_pkg holds:
  - MEMOP_W=3 and MEMOP_WORD=0, MEMOP_HALF=1, MEMOP_HALFU=2, MEMOP_BYTE=3, MEMOP_BYTEU=4.
  - The jal link offset constant, 8.
- One natural sub-module, data_mem: the array, synchronous reset clear, byte-lane write and combinational read. It takes clk, reset, we, addr, wdata and size, and returns rdata.
- Load extension and result mux stay in mw_stage.

Test Plan:
- Word store/load:
  - Stimulus: sw 0x12345678 to 0x10, then lw 0x10 with MemtoReg=1, WriteReg=8.
  - Required: next cycle Result_W=0x12345678, RegWrite_W=1, WriteReg_W=8.
- Byte and half lanes:
  - Stimulus: sw 0 to 0x20, sb 0x9A to 0x23, sh 0xBEEF to 0x20.
  - Required: lw 0x20 gives 0x9A00BEEF; lb 0x23 gives 0xFFFFFF9A; lbu 0x23 gives 0x0000009A; lh 0x20 gives 0xFFFFBEEF; lhu 0x20 gives 0x0000BEEF.
- jal and forwarding:
  - Stimulus: jal_M=1, pc_M=0x00003000, WriteReg=31.
  - Required: Fwd_M=0x00003008 in the same cycle; next cycle Result_W=0x00003008, WriteReg_W=31.
- $0 suppression and out-of-range store:
  - Stimulus: RegWrite_M=1 with WriteReg_M=0.
  - Required: RegWrite_W=0.
  - Stimulus: sw to 0x4000 with DM_ADDR_W=12.
  - Required: no memory word changes; lw 0x4000 gives 0.
- Reset mid-stream:
  - Stimulus: store 0xAAAAAAAA to 0x0; assert reset for one cycle together with a store of 0x55555555 to 0x4.
  - Required: all W outputs 0; lw 0x0 and lw 0x4 both return 0.
